bcd_to_binary: RTL and testbench

- Sequential reverse double-dabble converter: takes a packed BCD number and produces its unsigned binary value, one shift per clock.
- Inverse of the binary-to-BCD display path. Used to turn operator-entered decimal values (gate time, reference frequency) into binary for the counter core, and as a loopback checker for the BCD display path.
- Reports invalid BCD digits and overflow beyond OUT_WIDTH.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_rdd_step.sv | 31 +++
 rtl/bcd_to_binary.sv | 139 +++++++++++++
 tb/tb_bcd_to_binary.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
package bcd_pkg;

  localparam int BCD_DIGIT_W        = 4;
  localparam int DEFAULT_NUM_DIGITS = 10;

  // Reverse double-dabble correction: after each right shift, a digit that
  // picked up the carried-in half-weight bit (>= 8) is pulled back by 3.
  localparam int BCD_CORR_THRESH = 8;
  localparam int BCD_CORR_VAL    = 3;

  // Forward (binary-to-BCD) counterparts, kept beside the reverse constants.
  localparam int BIN2BCD_CORR_THRESH = 5;
  localparam int BIN2BCD_CORR_VAL    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // A BCD digit is only legal in the range 0..9.
  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_rdd_step.sv
// One combinational reverse double-dabble step: shift {bcd, bin} right by one,
// then correct every BCD digit that reached 8 or more by subtracting 3.
// The bin LSB falls off the end of the shift, so only the surviving upper
// bits of bin are taken as input; the full shifted bin is returned.
module bcd_rdd_step
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_i,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-2:0] bin_hi_i,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_o,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bin_o
);

  localparam int W = BCD_DIGIT_W * NUM_DIGITS;

  logic [W-1:0] bcd_shift;

  assign bcd_shift = {1'b0, bcd_i[W-1:1]};
  assign bin_o     = {bcd_i[0], bin_hi_i};

  // Per-digit correction, no borrow between digits.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [BCD_DIGIT_W-1:0] nib;
    assign nib = bcd_shift[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign bcd_o[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
        (nib >= BCD_DIGIT_W'(BCD_CORR_THRESH)) ? nib - BCD_DIGIT_W'(BCD_CORR_VAL) : nib;
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per
// clock). Flags illegal digits and results wider than OUT_WIDTH.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [OUT_WIDTH-1:0]              binary_o,
  output logic                              overflow_o,
  output logic                              invalid_o
);

  localparam int BIN_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  conv_state_e          state_q, state_d;
  logic [BIN_W-1:0]     bcd_q, bcd_d;
  // bin LSB is never read again once shifted out, so only the upper bits are kept.
  logic [BIN_W-2:0]     bin_q, bin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] binary_q, binary_d;
  logic                 overflow_q, overflow_d;
  logic                 invalid_q, invalid_d;
  logic                 done_q, done_d;

  logic [BIN_W-1:0]      step_bcd;
  logic [BIN_W-1:0]      step_bin;
  logic                  step_ovf;
  logic [NUM_DIGITS-1:0] digit_bad;
  logic                  in_invalid;

  bcd_rdd_step #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_step (
    .bcd_i    (bcd_q),
    .bin_hi_i (bin_q),
    .bcd_o    (step_bcd),
    .bin_o    (step_bin)
  );

  // Input validity is checked on the raw bus at the accepting edge.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_chk
    assign digit_bad[gi] = digit_invalid(bcd_i[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
  end
  assign in_invalid = |digit_bad;

  // Anything left above OUT_WIDTH after the final shift is overflow.
  if (OUT_WIDTH < BIN_W) begin : g_ovf
    assign step_ovf = |step_bin[BIN_W-1:OUT_WIDTH];
  end else begin : g_no_ovf
    assign step_ovf = 1'b0;
  end

  // Next-state, datapath and result-capture logic.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    binary_d   = binary_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bcd_d = bcd_i;
          bin_d = '0;
          cnt_d = '0;
          if (in_invalid) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            binary_d   = '0;
            overflow_d = 1'b0;
            invalid_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = step_bcd;
        bin_d = step_bin[BIN_W-1:1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          binary_d   = step_bin[OUT_WIDTH-1:0];
          overflow_d = step_ovf;
          invalid_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      binary_q   <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      binary_q   <= binary_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
      done_q     <= done_d;
    end
  end

  assign busy_o     = (state_q == ST_SHIFT);
  assign done_o     = done_q;
  assign binary_o   = binary_q;
  assign overflow_o = overflow_q;
  assign invalid_o  = invalid_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary against an arithmetic decimal model.
module tb_bcd_to_binary;

  localparam int NUM_DIGITS = 10;
  localparam int OUT_WIDTH  = 32;
  localparam int BIN_W      = 4 * NUM_DIGITS;
  localparam int VALID_LAT  = BIN_W + 1;

  logic                 clk;
  logic                 rst_i;
  logic                 start_i;
  logic [BIN_W-1:0]     bcd_i;
  logic                 busy_o;
  logic                 done_o;
  logic [OUT_WIDTH-1:0] binary_o;
  logic                 overflow_o;
  logic                 invalid_o;

  int vectors    = 0;
  int miscompares = 0;

  bcd_to_binary #(
    .NUM_DIGITS (NUM_DIGITS),
    .OUT_WIDTH  (OUT_WIDTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .bcd_i      (bcd_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .binary_o   (binary_o),
    .overflow_o (overflow_o),
    .invalid_o  (invalid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal value of a packed BCD word (digit k weighs 10^k).
  function automatic longint unsigned bcd_value(input logic [BIN_W-1:0] b);
    longint unsigned v = 0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) v = v * 10 + longint'(b[k*4 +: 4]);
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [BIN_W-1:0] b);
    bit bad = 0;
    for (int k = 0; k < NUM_DIGITS; k++) if (b[k*4 +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  // Decimal digits of a binary value, packed as BCD.
  function automatic logic [BIN_W-1:0] to_bcd(input longint unsigned v);
    logic [BIN_W-1:0] r = '0;
    longint unsigned  x = v;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Starts one conversion from an IDLE negedge; returns done latency in
  // cycles, busy cycle count, and whether done_o was still high one cycle later.
  task automatic convert(input logic [BIN_W-1:0] bcd, output int lat, output int busy_cnt,
                         output logic timed_out, output logic done_after);
    bcd_i   = bcd;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i   = 1'b0;
    bcd_i     = BIN_W'({$urandom, $urandom});
    lat       = 1;
    busy_cnt  = 0;
    timed_out = 1'b0;
    while (done_o !== 1'b1 && lat < 200) begin
      if (busy_o === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (done_o !== 1'b1) timed_out = 1'b1;
    @(negedge clk);
    done_after = done_o;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    bcd_i   = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy_o, done_o, overflow_o, invalid_o} !== 4'b0000 || binary_o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b ovf=%b inv=%b bin=%h, required all 0",
               busy_o, done_o, overflow_o, invalid_o, binary_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    $display("reset: outputs busy=%b done=%b bin=%h", busy_o, done_o, binary_o);
  endtask

  task automatic test_vectors();
    logic [BIN_W-1:0]     vb [5] = '{40'h0000000000, 40'h0012345678, 40'h4294967295,
                                     40'h4294967296, 40'h9999999999};
    logic [OUT_WIDTH-1:0] eb [5] = '{32'h00000000, 32'h00BC614E, 32'hFFFFFFFF,
                                     32'h00000000, 32'h540BE3FF};
    logic                 eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, bc;
    logic to, da;
    for (int i = 0; i < 5; i++) begin
      convert(vb[i], lat, bc, to, da);
      $display("vector %0d: bcd=%h bin=%h ovf=%b inv=%b lat=%0d busy=%0d",
               i, vb[i], binary_o, overflow_o, invalid_o, lat, bc);
      vectors++;
      if (to || lat != VALID_LAT) begin
        miscompares++;
        $display("FAIL vec%0d_latency: got %0d (timeout=%b), required %0d", i, lat, to, VALID_LAT);
      end
      vectors++;
      if (bc != BIN_W) begin
        miscompares++;
        $display("FAIL vec%0d_busy_cycles: got %0d, required %0d", i, bc, BIN_W);
      end
      vectors++;
      if (binary_o !== eb[i]) begin
        miscompares++;
        $display("FAIL vec%0d_binary: got %h, required %h", i, binary_o, eb[i]);
      end
      vectors++;
      if (overflow_o !== eo[i] || invalid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d_flags: ovf=%b inv=%b, required ovf=%b inv=0",
                 i, overflow_o, invalid_o, eo[i]);
      end
      vectors++;
      if (da !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d_done_pulse: done one cycle later=%b, required 0", i, da);
      end
    end
  endtask

  task automatic test_abort();
    logic saw_done = 1'b0;
    int lat, bc;
    logic to, da;
    bcd_i   = 40'h0012345678;
    start_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) saw_done = 1'b1;
      start_i = (k == 10);
      if (k == 10) bcd_i = 40'h0000009999;
      rst_i = (k == 20);
    end
    $display("abort: saw_done=%b busy=%b bin=%h ovf=%b", saw_done, busy_o, binary_o, overflow_o);
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: done seen=%b, required 0", saw_done);
    end
    vectors++;
    if ({busy_o, done_o, overflow_o, invalid_o} !== 4'b0000 || binary_o !== '0) begin
      miscompares++;
      $display("FAIL abort_reset_outputs: busy=%b done=%b ovf=%b inv=%b bin=%h, required all 0",
               busy_o, done_o, overflow_o, invalid_o, binary_o);
    end
    convert(40'h0012345678, lat, bc, to, da);
    $display("post-abort: bin=%h lat=%0d", binary_o, lat);
    vectors++;
    if (to || lat != VALID_LAT || binary_o !== 32'h00BC614E) begin
      miscompares++;
      $display("FAIL abort_fresh_convert: bin=%h lat=%0d, required 00bc614e lat %0d",
               binary_o, lat, VALID_LAT);
    end
  endtask

  task automatic test_invalid();
    int lat, bc;
    logic to, da;
    convert(40'h00000000A0, lat, bc, to, da);
    $display("invalid: bin=%h ovf=%b inv=%b lat=%0d busy=%0d", binary_o, overflow_o, invalid_o, lat, bc);
    vectors++;
    if (to || lat != 1 || bc != 0) begin
      miscompares++;
      $display("FAIL invalid_latency: lat=%0d busy=%0d, required lat 1 busy 0", lat, bc);
    end
    vectors++;
    if (invalid_o !== 1'b1 || overflow_o !== 1'b0 || binary_o !== '0) begin
      miscompares++;
      $display("FAIL invalid_result: inv=%b ovf=%b bin=%h, required inv=1 ovf=0 bin=0",
               invalid_o, overflow_o, binary_o);
    end
  endtask

  task automatic test_back_to_back();
    int   first = -1, second = -1, n = 0;
    logic held_ok = 1'b1;
    bcd_i   = 40'h0000054321;
    start_i = 1'b1;
    while (second < 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (done_o === 1'b1) begin
        if (first < 0) begin
          first = n;
          bcd_i = 40'h0000098765;
        end else begin
          second = n;
        end
      end
      if (first > 0 && n == first + 20 && (binary_o !== 32'd54321 || busy_o !== 1'b1))
        held_ok = 1'b0;
    end
    start_i = 1'b0;
    $display("back_to_back: done at %0d and %0d, bin=%h", first, second, binary_o);
    vectors++;
    if (second < 0 || second - first != VALID_LAT + 1) begin
      miscompares++;
      $display("FAIL b2b_period: got %0d, required %0d", second - first, VALID_LAT + 1);
    end
    vectors++;
    if (held_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_result_hold: previous result not held while busy, required 54321 held");
    end
    vectors++;
    if (binary_o !== 32'd98765) begin
      miscompares++;
      $display("FAIL b2b_second_result: got %h, required %h", binary_o, 32'd98765);
    end
    @(negedge clk);
  endtask

  task automatic test_random_digits();
    logic [BIN_W-1:0]     b;
    longint unsigned      v;
    logic                 bad, eovf;
    logic [OUT_WIDTH-1:0] ebin;
    int                   elat, lat, bc;
    logic                 to, da;
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        b[k*4 +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      bad  = bcd_bad(b);
      v    = bcd_value(b);
      ebin = bad ? '0 : v[OUT_WIDTH-1:0];
      eovf = bad ? 1'b0 : ((v >> OUT_WIDTH) != 0);
      elat = bad ? 1 : VALID_LAT;
      convert(b, lat, bc, to, da);
      $display("random %0d: bcd=%h bin=%h ovf=%b inv=%b lat=%0d", i, b, binary_o, overflow_o, invalid_o, lat);
      vectors++;
      if (to || lat != elat || binary_o !== ebin || overflow_o !== eovf || invalid_o !== bad) begin
        miscompares++;
        $display("FAIL random%0d: bin=%h ovf=%b inv=%b lat=%0d, required bin=%h ovf=%b inv=%b lat=%0d",
                 i, binary_o, overflow_o, invalid_o, lat, ebin, eovf, bad, elat);
      end
    end
  endtask

  task automatic test_loopback();
    logic [OUT_WIDTH-1:0] v;
    int   lat, bc;
    logic to, da;
    for (int i = 0; i < 1000; i++) begin
      v = $urandom;
      convert(to_bcd(longint'(v)), lat, bc, to, da);
      $display("loopback %0d: value=%h bin=%h ovf=%b inv=%b", i, v, binary_o, overflow_o, invalid_o);
      vectors++;
      if (to || binary_o !== v || overflow_o !== 1'b0 || invalid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL loopback%0d: bin=%h ovf=%b inv=%b timeout=%b, required bin=%h ovf=0 inv=0",
                 i, binary_o, overflow_o, invalid_o, to, v);
      end
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    bcd_i   = '0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_abort();
    test_invalid();
    test_back_to_back();
    test_random_digits();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
